// File: rtl/mem_pkg.sv
// Shared definitions for the block main memory: parameter defaults, FSM states
// and the constant helpers used for sizing and block-word slicing.
package mem_pkg;
    localparam int DEF_WORD_W        = 32;
    localparam int DEF_WORDS_PER_BLK = 4;
    localparam int DEF_ADDR_W        = 10;
    localparam int DEF_LATENCY       = 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Word 0 sits in the MSBs, so word k starts this many bits above bit 0.
    function automatic int blk_word_lsb(input int blk_w, input int word_w, input int k);
        return blk_w - (k + 1) * word_w;
    endfunction
endpackage

// File: rtl/block_mem_array.sv
// Word-organised storage with one block-wide read port and one block-wide write port.
// Reset reloads every word i with i+1.
module block_mem_array
    import mem_pkg::*;
#(
    parameter int WORD_W        = DEF_WORD_W,
    parameter int WORDS_PER_BLK = DEF_WORDS_PER_BLK,
    parameter int IDX_W         = 8,
    localparam int BLK_W        = WORD_W * WORDS_PER_BLK,
    localparam int DEPTH        = 1 << IDX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_wbase,
    input  logic [BLK_W-1:0] i_wdata,
    input  logic [IDX_W-1:0] i_rbase,
    output logic [BLK_W-1:0] o_rdata
);
    logic [WORD_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= WORD_W'(i + 1);
        end else if (i_we) begin
            for (int k = 0; k < WORDS_PER_BLK; k++)
                r_mem[i_wbase + IDX_W'(k)] <= i_wdata[blk_word_lsb(BLK_W, WORD_W, k) +: WORD_W];
        end
    end

    for (genvar k = 0; k < WORDS_PER_BLK; k++) begin : g_rd
        assign o_rdata[blk_word_lsb(BLK_W, WORD_W, k) +: WORD_W] = r_mem[i_rbase + IDX_W'(k)];
    end
endmodule

// File: rtl/block_main_memory.sv
// Clocked block-granular main memory: valid/ready request, fixed LATENCY, one-cycle
// response pulse. Holds the FSM, latency counter and request latches.
module block_main_memory
    import mem_pkg::*;
#(
    parameter int WORD_W        = DEF_WORD_W,
    parameter int WORDS_PER_BLK = DEF_WORDS_PER_BLK,
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int LATENCY       = DEF_LATENCY,
    localparam int OFS_W        = clog2(WORD_W / 8),
    localparam int BLK_OFS_W    = clog2(WORDS_PER_BLK),
    localparam int IDX_W        = ADDR_W - OFS_W,
    localparam int BLK_W        = WORD_W * WORDS_PER_BLK,
    localparam int CNT_W        = clog2(LATENCY + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [BLK_W-1:0]  req_wdata,
    output logic              resp_valid,
    output logic [BLK_W-1:0]  resp_rdata,
    output logic              busy
);
    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_write;
    logic [IDX_W-1:0]   r_base;
    logic [BLK_W-1:0]   r_wdata;
    logic [BLK_W-1:0]   r_rdata;

    logic               w_accept, w_enter_resp, w_cur_write;
    logic [IDX_W-1:0]   w_req_base, w_cur_base;
    logic [BLK_W-1:0]   w_cur_wdata, w_rdata;

    assign req_ready  = (r_state == IDLE);
    assign busy       = (r_state == WAIT) || (r_state == RESP);
    assign resp_valid = (r_state == RESP);
    assign resp_rdata = r_rdata;

    assign w_accept   = req_valid && req_ready;
    assign w_req_base = req_addr[ADDR_W-1:OFS_W] & ~((IDX_W'(1) << BLK_OFS_W) - IDX_W'(1));

    // With LATENCY == 1 the array is accessed on the accept edge itself, so the
    // live request is used in IDLE; otherwise the latched copy drives the array.
    assign w_cur_write = (r_state == IDLE) ? req_write  : r_write;
    assign w_cur_base  = (r_state == IDLE) ? w_req_base : r_base;
    assign w_cur_wdata = (r_state == IDLE) ? req_wdata  : r_wdata;

    assign w_enter_resp = ((r_state == IDLE) && w_accept && (LATENCY == 1)) ||
                          ((r_state == WAIT) && (r_cnt == CNT_W'(1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (LATENCY == 1) ? RESP : WAIT;
                    w_cnt_nxt   = CNT_W'(LATENCY - 1);
                end
            end
            WAIT: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) w_state_nxt = RESP;
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_write <= 1'b0;
            r_base  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_write <= req_write;
                r_base  <= w_req_base;
                r_wdata <= req_wdata;
            end
            if (w_enter_resp && !w_cur_write) r_rdata <= w_rdata;
        end
    end

    block_mem_array #(
        .WORD_W        (WORD_W),
        .WORDS_PER_BLK (WORDS_PER_BLK),
        .IDX_W         (IDX_W)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_enter_resp && w_cur_write),
        .i_wbase (w_cur_base),
        .i_wdata (w_cur_wdata),
        .i_rbase (w_cur_base),
        .o_rdata (w_rdata)
    );
endmodule

// File: tb/tb_block_main_memory.sv
// Scoreboard bench for block_main_memory: default configuration and a
// LATENCY=1 / 16-bit / 8-word / 9-bit-address configuration side by side.
module tb_block_main_memory;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic         v[2], wr[2], rdy[2], bsy[2], rv[2];
    logic [9:0]   addr[2];
    logic [127:0] wd[2], rd[2];
    int           LAT[2] = '{4, 1};

    block_main_memory dut0 (
        .clk(clk), .reset(reset), .req_valid(v[0]), .req_ready(rdy[0]),
        .req_write(wr[0]), .req_addr(addr[0]), .req_wdata(wd[0]),
        .resp_valid(rv[0]), .resp_rdata(rd[0]), .busy(bsy[0])
    );

    block_main_memory #(.WORD_W(16), .WORDS_PER_BLK(8), .ADDR_W(9), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(v[1]), .req_ready(rdy[1]),
        .req_write(wr[1]), .req_addr(addr[1][8:0]), .req_wdata(wd[1]),
        .resp_valid(rv[1]), .resp_rdata(rd[1]), .busy(bsy[1])
    );

    typedef struct {
        logic [127:0] data;
        int           cyc;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];

    // Reference contents: plain word arrays plus the last read block per DUT.
    logic [31:0]  m0[256];
    logic [15:0]  m1[256];
    logic [127:0] last[2];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic init_models();
        for (int i = 0; i < 256; i++) begin
            m0[i] = 32'(i + 1);
            m1[i] = 16'(i + 1);
        end
        last[0] = '0;
        last[1] = '0;
    endtask

    function automatic logic [127:0] model_access(input int sel, input bit w,
                                                  input logic [9:0] a, input logic [127:0] d);
        logic [127:0] r;
        int b;
        r = '0;
        if (sel == 0) begin
            b = (int'(a) / 4) / 4 * 4;
            for (int k = 0; k < 4; k++)
                if (w) m0[b + k] = d[127 - 32 * k -: 32];
                else   r = {r[95:0], m0[b + k]};
        end else begin
            b = (int'(a[8:0]) / 2) / 8 * 8;
            for (int k = 0; k < 8; k++)
                if (w) m1[b + k] = d[127 - 16 * k -: 16];
                else   r = {r[111:0], m1[b + k]};
        end
        if (!w) last[sel] = r;
        return last[sel];
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!reset && rv[0]) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_resp0 actual=1 required=0");
            end else begin
                e = q0.pop_front();
                check("rdata0", rd[0], e.data);
                check("resp_cycle0", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset && rv[1]) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_resp1 actual=1 required=0");
            end else begin
                e = q1.pop_front();
                check("rdata1", rd[1], e.data);
                check("resp_cycle1", cyc, e.cyc);
            end
        end
    end

    // Called at a negedge; returns at the negedge where req_ready must be back.
    task automatic issue(input int sel, input bit w, input logic [9:0] a,
                         input logic [127:0] d, input bit hold, output int n);
        exp_t e;
        int budget;
        v[sel] = 1'b1; wr[sel] = w; addr[sel] = a; wd[sel] = d;
        budget = 0;
        n = -1;
        while (!rdy[sel] && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!rdy[sel]) begin
            checks++; errors++;
            $display("FAIL accept_timeout actual=0 required=1");
            v[sel] = 1'b0;
            return;
        end
        n = cyc;
        e.data = model_access(sel, w, a, d);
        e.cyc  = n + LAT[sel];
        if (sel == 0) q0.push_back(e);
        else          q1.push_back(e);
        for (int i = 1; i <= LAT[sel]; i++) begin
            @(negedge clk);
            if (i == 1) begin
                if (!hold) v[sel] = 1'b0;
                addr[sel] = 10'($urandom);
                wd[sel]   = {$urandom, $urandom, $urandom, $urandom};
                wr[sel]   = 1'($urandom);
            end
            check("ready_busy_in_flight", {rdy[sel], bsy[sel]}, 2'b01);
        end
        @(negedge clk);
        check("ready_back", {rdy[sel], bsy[sel]}, 2'b10);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int n1, n2;
        for (int s = 0; s < 2; s++) begin
            v[s] = 1'b0; wr[s] = 1'b0; addr[s] = '0; wd[s] = '0;
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("reset_ready_busy_valid", {rdy[s], bsy[s], rv[s]}, 3'b100);
            check("reset_rdata", rd[s], '0);
        end
        reset = 1'b0;
        init_models();
        @(negedge clk);

        issue(0, 1'b0, 10'h000, '0, 1'b0, n1);
        issue(0, 1'b0, 10'h3F6, '0, 1'b0, n1);
        issue(0, 1'b1, 10'h024, 128'hAAAA0001_BBBB0002_CCCC0003_DDDD0004, 1'b0, n1);
        issue(0, 1'b0, 10'h020, '0, 1'b0, n1);
        issue(0, 1'b0, 10'h030, '0, 1'b0, n1);

        // Request held while busy must wait for the first to finish.
        issue(0, 1'b1, 10'h10C, {$urandom, $urandom, $urandom, $urandom}, 1'b1, n1);
        issue(0, 1'b0, 10'h108, '0, 1'b0, n2);
        check("blocked_accept_cycle", n2, n1 + LAT[0] + 1);

        // Reset during WAIT of a write: no response, no commit.
        v[0] = 1'b1; wr[0] = 1'b1; addr[0] = 10'h040;
        wd[0] = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        v[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        init_models();
        check("mid_reset_ready_busy", {rdy[0], bsy[0], rv[0]}, 3'b100);
        check("mid_reset_rdata", rd[0], '0);
        repeat (6) @(negedge clk);
        issue(0, 1'b0, 10'h040, '0, 1'b0, n1);

        repeat (40)
            issue(0, 1'($urandom_range(0, 1)), 10'($urandom),
                  {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)), n1);
        v[0] = 1'b0;

        issue(1, 1'b0, 10'h000, '0, 1'b0, n1);
        issue(1, 1'b1, 10'h012, {$urandom, $urandom, $urandom, $urandom}, 1'b0, n1);
        issue(1, 1'b0, 10'h010, '0, 1'b0, n1);
        issue(1, 1'b0, 10'h1FF, '0, 1'b0, n1);
        repeat (30)
            issue(1, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 511)),
                  {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)), n1);
        v[1] = 1'b0;

        repeat (8) @(negedge clk);
        check("queue0_drained", 128'(q0.size()), '0);
        check("queue1_drained", 128'(q1.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/block_main_memory.md
# block_main_memory

Parametrised, clocked successor to the combinational main-memory model: a word-organised backing store serving whole-block reads and writes to the cache over a valid/ready request channel and a one-cycle response pulse. Access latency is a parameter, so cache miss penalties become cycle-accurate. Sits below the cache controller in every cache configuration of the project; block size, word width and depth track the cache parameters.

## Interface
- `WORD_W`, 32: word width in bits; a power of two and ≥ 8.
- `WORDS_PER_BLK`, 4: words per block; a power of two and ≥ 1.
- `ADDR_W`, 10: byte-address width.
- `LATENCY`, 4: cycles from request accept to response; ≥ 1.
- Derived values:
  - `OFS_W = clog2(WORD_W/8)`
  - `BLK_OFS_W = clog2(WORDS_PER_BLK)`
  - `DEPTH = 2^(ADDR_W-OFS_W)` words
  - `BLK_W = WORD_W*WORDS_PER_BLK`
- `clk`  in  1  the single clock; rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  a request is present.
- `req_ready`  out  1  the block can accept a request; high only in IDLE.
- `req_write`  in  1  0 = block read, 1 = block write.
- `req_addr`  in  ADDR_W  byte address; any byte inside the target block.
- `req_wdata`  in  BLK_W  write block; word 0 is in the MSBs.
- `resp_valid`  out  1  one-cycle completion pulse, for both reads and writes.
- `resp_rdata`  out  BLK_W  read block with word 0 in the MSBs; valid while `resp_valid` is high.
- `busy`  out  1  high in WAIT and RESP.

## Operation
- **Handshake:** a request is accepted on a rising edge with `req_valid && req_ready`. At accept the block latches:
  - `req_write`
  - the block base, i.e. `req_addr` with its low `OFS_W+BLK_OFS_W` bits cleared
  - `req_wdata`
  
  Input changes after accept are ignored.
- **Addressing:** all accesses are block-aligned. Word k of the block is the word at word index `base_word + k`. Blocks never straddle the top of memory, so there is no wrap-around.
- **Read:** `resp_rdata = {mem[b], mem[b+1], …, mem[b+WORDS_PER_BLK-1]}`.
- **Write:** all `WORDS_PER_BLK` words are written. Word k comes from slice `req_wdata[BLK_W-1-k*WORD_W -: WORD_W]`. The memory update happens on the edge that enters RESP. On a write response, `resp_rdata` holds its previous value.
- **FSM:**
  - IDLE → WAIT on accept, with the counter loaded to `LATENCY-1`. If `LATENCY == 1`, IDLE → RESP directly.
  - WAIT: the counter decrements each cycle; at 1 the FSM moves to RESP.
  - RESP: `resp_valid` = 1 for exactly one cycle, then the FSM returns to IDLE unconditionally. No response backpressure.
- **Contents after reset:** memory word i = i+1, truncated to `WORD_W` bits.
- **Reset values:**
  - FSM state = IDLE, counter = 0, `resp_valid` = 0, `resp_rdata` = 0.
  - `busy` = 0 and `req_ready` = 1 from the first edge with reset high.
  - Memory is re-initialised to the pattern above.
- **Reset mid-operation:** the transaction is dropped with no response. A write interrupted before the RESP edge is not committed.
- **Simultaneous events:** `reset` overrides accept. A `req_valid` asserted while the block is busy is held by the requester and not accepted.

## Timing
- Accept edge at cycle T → `resp_valid` high during cycle T+LATENCY → `req_ready` high again at T+LATENCY+1.
- Throughput: one block per `LATENCY+1` cycles.
- Read data is registered: it is sampled from the array on the edge entering RESP and is stable for the whole RESP cycle.
- `req_ready` and `busy` are decoded combinationally from the registered state; no input-to-output combinational path.
- Write data reaches the array on the edge entering RESP. A read accepted in the following IDLE cycle returns the new data.

## Structure
- Shared package `mem_pkg`:
  - default parameter constants
  - state enum {IDLE, WAIT, RESP}
  - `clog2` function
  - block-word slicing helper function
- One natural sub-module: `block_mem_array`, the storage array. It provides:
  - one block-wide read port and one block-wide write port on the word index
  - reset re-initialisation
- `block_main_memory` holds the FSM, latency counter and request latches.

## Test plan
- **Reset read:** reset, then read at addr 0x000 with `LATENCY` = 4 → `resp_valid` at T+4 with `resp_rdata` = {1,2,3,4}; `req_ready` low during T+1…T+4.
- **Unaligned read near the top:** read at addr 0x3F6 → block base 0x3F0, `resp_rdata` = {253,254,255,256}, no wrap.
- **Write then read back:** write {A,B,C,D} at addr 0x024, then read 0x020 → {A,B,C,D}. A read of 0x030 still returns {13,14,15,16}.
- **Input changes and blocked requests:** change `req_addr`/`req_wdata` after accept, and hold `req_valid` high while busy → the latched request completes unchanged; the second request is accepted only at T+LATENCY+1.
- **Reset mid-write:** assert reset during WAIT of a write to 0x040 → no `resp_valid`; a later read of 0x040 returns {17,18,19,20}.
- **Parameter sweep:** `LATENCY` = 1, `WORD_W` = 16, `WORDS_PER_BLK` = 8, `ADDR_W` = 9 → read at 0 responds at T+1 with {1..8}; `req_ready` is back at T+2.
